bob_addr_multi: RTL
===================

Name: bob_addr_multi

Overview:
Parametrised successor to the single-entry branch-order-buffer (BOB) address allocator. It manages a circular buffer of DEPTH entries, where DEPTH need not be a power of two.
- Allocates up to NALLOC entries per cycle at the tail.
- Retires up to NRET entries per cycle at the head.
- Reports occupancy and free space.
- On an exception, flushes all live entries.
It sits between rename/dispatch (allocation side) and the retire logic, and supplies addresses to the bob_ram read and write ports.

Parameters:
DEPTH, 48, number of buffer entries (2..2**AW)
AW, 6, address width; must satisfy 2**AW >= DEPTH
NALLOC, 2, maximum allocations per cycle
NRET, 2, maximum retirements per cycle
CW, 7, count width; must satisfy 2**CW > DEPTH

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
except  in  1  flush all live entries
new_cnt  in  $clog2(NALLOC+1)  number of entries requested this cycle
stall  in  1  external stall; blocks allocation
new_addr  out  NALLOC*AW  slot i = (tail+i) mod DEPTH; slot 0 in the low bits
doStall  out  1  requested allocation does not fit
new_grant  out  1  allocation is accepted this cycle
ret_cnt  in  $clog2(NRET+1)  number of entries to retire this cycle
retire_addr  out  NRET*AW  slot j = (head+j) mod DEPTH; registered
retire_addr_nxt  out  AW  next-cycle head value, combinational; feeds bob_ram read_addr
count  out  CW  number of live entries (registered)
free  out  CW  DEPTH-count (combinational)
hasRetire  out  $clog2(NRET+1)  min(count, NRET)

Behaviour:
- Reset (asynchronous): head=0, tail=0, count=0. So new_addr slot i=i, retire_addr slot j=j, free=DEPTH, hasRetire=0, doStall=(new_cnt>DEPTH), and retire_addr_nxt=0 while rst is high.
- All modular adds are ptr+k, with DEPTH subtracted when the sum is >= DEPTH. k <= max(NALLOC,NRET) <= DEPTH, so one conditional subtract is enough. There is no power-of-two masking.
- Retire:
  - eff_ret = min(ret_cnt, count).
  - An over-request is clamped; it is never an error and never underflows.
- Allocation:
  - doStall = new_cnt > free + eff_ret. Same-cycle retirement frees space in time.
  - new_grant = new_cnt!=0 && !stall && !doStall && !except.
  - Allocation is all-or-nothing: there are no partial grants.
- Register update when not except:
  - tail += new_grant ? new_cnt : 0
  - head += eff_ret
  - count = count + granted - eff_ret, all in one adder path. Simultaneous alloc and retire is legal.
- except (dominates everything except rst):
  - head <= tail, count <= 0, no grant, no retire that cycle.
  - tail is unchanged, so new_addr continues from the pre-flush tail.
- retire_addr_nxt:
  - rst: 0.
  - except: tail.
  - otherwise: head+eff_ret mod DEPTH.
- Latency:
  - A grant in cycle N is visible in count and free at N+1.
  - An entry allocated in cycle N may retire from cycle N+1.
- Full: count==DEPTH means free=0. With eff_ret=0, any new_cnt>0 gives doStall=1.
- Empty: count==0 means hasRetire=0, and ret_cnt is ignored.
- Wrap-around: within one cycle, the slot addresses cross DEPTH-1 to 0 contiguously.
- Reset mid-operation: state clears immediately, asynchronously, regardless of clk.
- Invariant (assertion): count == (tail-head) mod DEPTH, except when count==DEPTH, where head==tail.

Decomposition:
- Shared package bob_pkg:
  - BOB_DEPTH (48), BOB_AW (6), BOB_NALLOC, BOB_NRET.
  - bob_ptr_t typedef; bob_cnt_t typedef.
- One sub-module, bob_ptr_add (ptr, k -> (ptr+k) mod DEPTH, parameter DEPTH/AW).
  - Instantiated per new_addr slot, per retire_addr slot, and for head/tail next.

Test Plan:
1. Reset, then new_cnt=2 with stall=0 on every cycle:
   - Grants occur for 24 cycles; then count=48, free=0, and doStall=1 with new_grant=0.
   - new_addr of the last grant is {47,46}.
2. Tail=47, count=10, new_cnt=2:
   - new_addr slots {0,47}; next cycle tail=1, count=12.
   - Repeat with head=47, ret_cnt=2 -> retire_addr_nxt=1.
3. Full (count=48), new_cnt=2, ret_cnt=2 in the same cycle:
   - doStall=0, new_grant=1; count stays 48; head and tail both advance by 2.
4. count=1, ret_cnt=2:
   - eff_ret=1, hasRetire=1; next cycle count=0, head==tail, hasRetire=0.
5. count=20, tail=30, except=1 together with new_cnt=2 and ret_cnt=2:
   - No grant; retire_addr_nxt=30; next cycle count=0, head=30, tail=30.
6. Assert rst asynchronously between clock edges with count=17:
   - count, head and tail go to 0 immediately, before the next edge.
   - After rst deasserts, allocation restarts at address 0.

Source files
------------

// File: rtl/bob_pkg.sv
// Shared widths and types for the branch-order-buffer address allocator.
package bob_pkg;
  localparam int BOB_DEPTH  = 48;
  localparam int BOB_AW     = 6;
  localparam int BOB_NALLOC = 2;
  localparam int BOB_NRET   = 2;
  localparam int BOB_CW     = 7;

  typedef logic [BOB_AW-1:0] bob_ptr_t;
  typedef logic [BOB_CW-1:0] bob_cnt_t;
endpackage

// File: rtl/bob_ptr_add.sv
// Circular pointer add: (ptr + k) mod DEPTH, with DEPTH not necessarily a power of two.
module bob_ptr_add
  import bob_pkg::*;
#(
  parameter int DEPTH = BOB_DEPTH,
  parameter int AW    = BOB_AW,
  parameter int KW    = 2
) (
  input  logic [AW-1:0] ptr,
  input  logic [KW-1:0] k,
  output logic [AW-1:0] sum
);
  logic [AW:0] raw;

  // k never exceeds DEPTH, so a single conditional subtract wraps correctly
  assign raw = {1'b0, ptr} + (AW+1)'(k);
  assign sum = (raw >= (AW+1)'(DEPTH)) ? AW'(raw - (AW+1)'(DEPTH)) : raw[AW-1:0];
endmodule

// File: rtl/bob_addr_multi.sv
// Multi-alloc / multi-retire head/tail allocator for a circular BOB of DEPTH entries.
module bob_addr_multi
  import bob_pkg::*;
#(
  parameter int DEPTH  = BOB_DEPTH,
  parameter int AW     = BOB_AW,
  parameter int NALLOC = BOB_NALLOC,
  parameter int NRET   = BOB_NRET,
  parameter int CW     = BOB_CW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         except,
  input  logic [$clog2(NALLOC+1)-1:0]  new_cnt,
  input  logic                         stall,
  output logic [NALLOC*AW-1:0]         new_addr,
  output logic                         doStall,
  output logic                         new_grant,
  input  logic [$clog2(NRET+1)-1:0]    ret_cnt,
  output logic [NRET*AW-1:0]           retire_addr,
  output logic [AW-1:0]                retire_addr_nxt,
  output logic [CW-1:0]                count,
  output logic [CW-1:0]                free,
  output logic [$clog2(NRET+1)-1:0]    hasRetire
);
  localparam int NW   = $clog2(NALLOC+1);
  localparam int RW   = $clog2(NRET+1);
  localparam int KMAX = (NALLOC > NRET) ? NALLOC : NRET;
  localparam int KW   = $clog2(KMAX+1);

  function automatic logic [NRET*AW-1:0] ret_rst_val();
    logic [NRET*AW-1:0] r;
    r = '0;
    for (int j = 0; j < NRET; j++) r[j*AW +: AW] = AW'(j);
    return r;
  endfunction

  logic [AW-1:0]      head, tail, head_adv, tail_adv, head_nxt;
  logic [RW-1:0]      eff_ret;
  logic [NW-1:0]      grant_cnt;
  logic [CW-1:0]      count_nxt;
  logic [NRET*AW-1:0] ret_slot_nxt;
  logic [CW-1:0]      span;

  assign free      = CW'(DEPTH) - count;
  assign hasRetire = (count < CW'(NRET)) ? RW'(count) : RW'(NRET);
  assign eff_ret   = (CW'(ret_cnt) <= count) ? ret_cnt : RW'(count);

  // Same-cycle retirement counts toward available space
  assign doStall   = (CW+1)'(new_cnt) > ((CW+1)'(free) + (CW+1)'(eff_ret));
  assign new_grant = (new_cnt != '0) && !stall && !doStall && !except;
  assign grant_cnt = new_grant ? new_cnt : '0;
  assign count_nxt = count + CW'(grant_cnt) - CW'(eff_ret);

  bob_ptr_add #(.DEPTH(DEPTH), .AW(AW), .KW(KW)) u_tail_add (
    .ptr(tail), .k(KW'(grant_cnt)), .sum(tail_adv)
  );

  bob_ptr_add #(.DEPTH(DEPTH), .AW(AW), .KW(KW)) u_head_add (
    .ptr(head), .k(KW'(eff_ret)), .sum(head_adv)
  );

  always_comb begin
    head_nxt = head_adv;
    if (rst)         head_nxt = '0;
    else if (except) head_nxt = tail;
  end

  assign retire_addr_nxt = head_nxt;

  for (genvar i = 0; i < NALLOC; i++) begin : g_new
    bob_ptr_add #(.DEPTH(DEPTH), .AW(AW), .KW(KW)) u_new_add (
      .ptr(tail), .k(KW'(i)), .sum(new_addr[i*AW +: AW])
    );
  end

  // Retire slots are precomputed from the next head so the output is registered
  for (genvar j = 0; j < NRET; j++) begin : g_ret
    bob_ptr_add #(.DEPTH(DEPTH), .AW(AW), .KW(KW)) u_ret_add (
      .ptr(head_nxt), .k(KW'(j)), .sum(ret_slot_nxt[j*AW +: AW])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      retire_addr <= ret_rst_val();
    end else begin
      head        <= head_nxt;
      tail        <= except ? tail : tail_adv;
      count       <= except ? '0 : count_nxt;
      retire_addr <= ret_slot_nxt;
    end
  end

  always_comb begin
    span = (tail >= head) ? CW'(tail - head) : (CW'(DEPTH) - CW'(head) + CW'(tail));
  end

  a_occupancy: assert property (@(posedge clk) disable iff (rst)
    (count == CW'(DEPTH)) ? (head == tail) : (count == span));
endmodule
